comparator_injector: RTL and testbench
======================================

COMPARATOR_INJECTOR -- requirements
Module: comparator_injector

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 fire_pulse  in  1  pulse-train request; a rising edge starts a train.
REQ-005 num_pulses  in  12  number of pulses per train.
REQ-006 pulse_width  in  4  pulse high time minus 1, in clocks.
REQ-007 bx_delay  in  4  clocks from pulse end to the sample point, minus 1.
REQ-008 compin_inject  in  1  enables driving compin during pulses.
REQ-009 halfstrips  in  32  comparator halfstrip hit bits.
REQ-010 compout  in  1  comparator output under test.
REQ-011 compout_expect  in  1  expected compout value at the sample point.
REQ-012 active_halfstrip  in  5  index of the halfstrip being injected.
REQ-013 halfstrip_mask_en  in  1  when 1, compare only the active halfstrip bit.
REQ-014 thresholds_errcnt_rst, offsets_errcnt_rst, compout_errcnt_rst  in  1 each  synchronous clear of the matching counter.
REQ-015 pulse_en  out  1  high while a pulse is being driven.
REQ-016 compin  out  1  comparator injection strobe.
REQ-017 pulser_ready  out  1  high when idle and able to accept fire_pulse.
REQ-018 halfstrips_last  out  32  halfstrips captured at the most recent sample point.
REQ-019 compout_last  out  1  compout captured at the most recent sample point.
REQ-020 thresholds_errcnt, offsets_errcnt, compout_errcnt  out  16 each  error counters.

Function
REQ-021 Pulser FSM states:
- IDLE: pulser_ready=1.
- PULSE: pulse_en=1 for pulse_width+1 clocks.
- WAIT: bx_delay+1 clocks; the last WAIT clock is the sample point.
REQ-022 Start condition: a rising edge of fire_pulse (previous-value register) detected at an edge in IDLE with num_pulses!=0 enters PULSE on that edge; pulse_en goes high 1 clock after fire_pulse rises.
REQ-023 Edges of fire_pulse outside IDLE are ignored; a held-high fire_pulse starts exactly one train.
REQ-024 num_pulses=0: no pulse is generated and pulser_ready stays 1.
REQ-025 After the sample point: if pulses sent < num_pulses, go to PULSE; else go to IDLE.
REQ-026 Pulse period is pulse_width+bx_delay+2 clocks.
REQ-027 compin = pulse_en AND compin_inject, registered or combinational consistently, with zero added latency relative to pulse_en.
REQ-028 At each sample point, capture halfstrips into halfstrips_last and compout into compout_last.
REQ-029 Threshold check at each sample point:
- expected pattern = one-hot bit active_halfstrip.
- mask_en=1: error if halfstrips[active_halfstrip]!=1.
- mask_en=0: error if halfstrips != expected pattern.
- thresholds_errcnt increments by 1 per failing sample.
REQ-030 Offset check: in IDLE, any halfstrips bit set on a clock increments offsets_errcnt by 1 per such clock.
REQ-031 Compout check: at each sample point, compout!=compout_expect increments compout_errcnt by 1.
REQ-032 Counter rules:
- all counters saturate at 0xFFFF; no wrap.
- a counter's _rst input has priority over a simultaneous increment.
- a counter reset affects only its own counter.

Reset
REQ-033 reset=0 at an edge forces:
- FSM to IDLE, pulse counter to 0, fire_pulse edge register to 0.
- pulse_en=0, compin=0, pulser_ready=1.
- halfstrips_last=0, compout_last=0, all counters=0.
REQ-034 Reset asserted mid-train aborts the train at that edge; no further pulses or samples occur.

Verification
REQ-035 num_pulses=3, bx_delay=12, pulse_width=0, fire_pulse rises before cycle 0 -> pulse_en high at cycles 1, 15, 29 only; sample points at 14, 28, 42; pulser_ready=1 from cycle 43.
REQ-036 Same train, halfstrips=0, mask_en=1, active_halfstrip=17 -> thresholds_errcnt=3, halfstrips_last=0.
REQ-037 halfstrips=0x00020000 held only during WAIT, compout=compout_expect -> thresholds_errcnt=0, compout_errcnt=0, offsets_errcnt=0.
REQ-038 compin_inject=0 during a train -> compin stays 0 while pulse_en still pulses; compout_expect=1 with compout=0 -> compout_errcnt=num_pulses.
REQ-039 halfstrips=1 held in IDLE for 70000 clocks -> offsets_errcnt=0xFFFF; then offsets_errcnt_rst=1 -> offsets_errcnt=0 on the next clock, other counters unchanged.
REQ-040 reset=0 asserted at cycle 20 of the REQ-035 train -> pulse_en=0 and pulser_ready=1 after that edge; no pulse at cycle 29.

Source files
------------

// File: rtl/comparator_injector.sv
// Comparator test pulser: fires trains of injection pulses, samples the comparator
// halfstrips and compout at a programmable point after each pulse, and counts errors.
module comparator_injector (
  input  logic        clock,
  input  logic        reset,
  input  logic        fire_pulse,
  input  logic [11:0] num_pulses,
  input  logic [3:0]  pulse_width,
  input  logic [3:0]  bx_delay,
  input  logic        compin_inject,
  input  logic [31:0] halfstrips,
  input  logic        compout,
  input  logic        compout_expect,
  input  logic [4:0]  active_halfstrip,
  input  logic        halfstrip_mask_en,
  input  logic        thresholds_errcnt_rst,
  input  logic        offsets_errcnt_rst,
  input  logic        compout_errcnt_rst,
  output logic        pulse_en,
  output logic        compin,
  output logic        pulser_ready,
  output logic [31:0] halfstrips_last,
  output logic        compout_last,
  output logic [15:0] thresholds_errcnt,
  output logic [15:0] offsets_errcnt,
  output logic [15:0] compout_errcnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        fire_prev;
  logic [11:0] sent;
  logic [3:0]  timer;

  logic        fire_rise;
  logic        start;
  logic        pulse_done;
  logic        sample_point;
  logic        more_pulses;
  logic [31:0] expected_pattern;
  logic        threshold_error;
  logic        offset_error;
  logic        compout_error;

  assign fire_rise    = fire_pulse & ~fire_prev;
  assign start        = (state == IDLE) && fire_rise && (num_pulses != 12'd0);
  assign pulse_done   = (state == PULSE) && (timer == pulse_width);
  assign sample_point = (state == WAIT) && (timer == bx_delay);
  assign more_pulses  = sent < num_pulses;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PULSE;
      PULSE:   if (pulse_done) state_next = WAIT;
      WAIT:    if (sample_point) state_next = more_pulses ? PULSE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      fire_prev <= 1'b0;
      sent      <= 12'd0;
      timer     <= 4'd0;
    end else begin
      state     <= state_next;
      fire_prev <= fire_pulse;
      // The timer restarts on every state change and counts clocks within a phase.
      if (state_next != state) timer <= 4'd0;
      else                     timer <= timer + 4'd1;
      if (start)                           sent <= 12'd1;
      else if (sample_point && more_pulses) sent <= sent + 12'd1;
    end
  end

  assign pulse_en     = (state == PULSE);
  assign compin       = pulse_en & compin_inject;
  assign pulser_ready = (state == IDLE);

  assign expected_pattern = 32'd1 << active_halfstrip;
  assign threshold_error  = sample_point &&
                            (halfstrip_mask_en ? !halfstrips[active_halfstrip]
                                               : (halfstrips != expected_pattern));
  assign offset_error     = (state == IDLE) && (halfstrips != 32'd0);
  assign compout_error    = sample_point && (compout != compout_expect);

  // Saturating counter step; a clear wins over a simultaneous increment.
  function automatic logic [15:0] count_next(input logic [15:0] cnt,
                                             input logic        clr,
                                             input logic        inc);
    logic [15:0] result;
    result = cnt;
    if (clr)                           result = 16'd0;
    else if (inc && cnt != 16'hFFFF)   result = cnt + 16'd1;
    return result;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      halfstrips_last   <= 32'd0;
      compout_last      <= 1'b0;
      thresholds_errcnt <= 16'd0;
      offsets_errcnt    <= 16'd0;
      compout_errcnt    <= 16'd0;
    end else begin
      if (sample_point) begin
        halfstrips_last <= halfstrips;
        compout_last    <= compout;
      end
      thresholds_errcnt <= count_next(thresholds_errcnt, thresholds_errcnt_rst, threshold_error);
      offsets_errcnt    <= count_next(offsets_errcnt, offsets_errcnt_rst, offset_error);
      compout_errcnt    <= count_next(compout_errcnt, compout_errcnt_rst, compout_error);
    end
  end

endmodule

// File: tb/tb_comparator_injector.sv
// Directed bench for comparator_injector: pulse schedules, sample captures,
// error counters, saturation, counter clears and reset abort.
module tb_comparator_injector;

  logic        clock = 1'b0;
  logic        reset;
  logic        fire_pulse;
  logic [11:0] num_pulses;
  logic [3:0]  pulse_width;
  logic [3:0]  bx_delay;
  logic        compin_inject;
  logic [31:0] halfstrips;
  logic        compout;
  logic        compout_expect;
  logic [4:0]  active_halfstrip;
  logic        halfstrip_mask_en;
  logic        thresholds_errcnt_rst;
  logic        offsets_errcnt_rst;
  logic        compout_errcnt_rst;
  logic        pulse_en;
  logic        compin;
  logic        pulser_ready;
  logic [31:0] halfstrips_last;
  logic        compout_last;
  logic [15:0] thresholds_errcnt;
  logic [15:0] offsets_errcnt;
  logic [15:0] compout_errcnt;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  comparator_injector dut (
    .clock                 (clock),
    .reset                 (reset),
    .fire_pulse            (fire_pulse),
    .num_pulses            (num_pulses),
    .pulse_width           (pulse_width),
    .bx_delay              (bx_delay),
    .compin_inject         (compin_inject),
    .halfstrips            (halfstrips),
    .compout               (compout),
    .compout_expect        (compout_expect),
    .active_halfstrip      (active_halfstrip),
    .halfstrip_mask_en     (halfstrip_mask_en),
    .thresholds_errcnt_rst (thresholds_errcnt_rst),
    .offsets_errcnt_rst    (offsets_errcnt_rst),
    .compout_errcnt_rst    (compout_errcnt_rst),
    .pulse_en              (pulse_en),
    .compin                (compin),
    .pulser_ready          (pulser_ready),
    .halfstrips_last       (halfstrips_last),
    .compout_last          (compout_last),
    .thresholds_errcnt     (thresholds_errcnt),
    .offsets_errcnt        (offsets_errcnt),
    .compout_errcnt        (compout_errcnt)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Cycle c is the clock period following the c-th rising edge after fire_pulse rises.
  function automatic bit in_train(int c, int n, int pw, int bd);
    return (c >= 1) && (c <= n * (pw + bd + 2));
  endfunction

  function automatic bit exp_pulse(int c, int n, int pw, int bd);
    return in_train(c, n, pw, bd) && (((c - 1) % (pw + bd + 2)) <= pw);
  endfunction

  function automatic bit exp_wait(int c, int n, int pw, int bd);
    return in_train(c, n, pw, bd) && (((c - 1) % (pw + bd + 2)) > pw);
  endfunction

  // Drives one train; pat is presented on halfstrips only during WAIT cycles.
  // abort_at != 0 pulls reset low at that edge and releases it right after.
  task automatic run_train(input int n, input int pw, input int bd, input logic [31:0] pat,
                           input logic inject, input int cycles, input int abort_at);
    bit live;
    @(negedge clock);
    num_pulses    = n[11:0];
    pulse_width   = pw[3:0];
    bx_delay      = bd[3:0];
    compin_inject = inject;
    halfstrips    = 32'd0;
    fire_pulse    = 1'b1;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clock);
      live = (abort_at == 0) || (c < abort_at);
      check($sformatf("pulse_en@%0d", c), pulse_en, live && exp_pulse(c, n, pw, bd));
      check($sformatf("compin@%0d", c), compin, live && inject && exp_pulse(c, n, pw, bd));
      check($sformatf("ready@%0d", c), pulser_ready, !live || !in_train(c, n, pw, bd));
      halfstrips = (live && exp_wait(c, n, pw, bd)) ? pat : 32'd0;
      if (abort_at != 0 && c == abort_at - 1) begin
        reset      = 1'b0;
        fire_pulse = 1'b0;
      end
      if (abort_at != 0 && c == abort_at) reset = 1'b1;
    end
    halfstrips = 32'd0;
    fire_pulse = 1'b0;
  endtask

  task automatic check_counters(input string tag, input logic [15:0] thr,
                                input logic [15:0] off, input logic [15:0] cmp);
    check({tag, "_thr"}, thresholds_errcnt, thr);
    check({tag, "_off"}, offsets_errcnt, off);
    check({tag, "_cmp"}, compout_errcnt, cmp);
  endtask

  initial begin
    reset                 = 1'b0;
    fire_pulse            = 1'b0;
    num_pulses            = 12'd0;
    pulse_width           = 4'd0;
    bx_delay              = 4'd0;
    compin_inject         = 1'b0;
    halfstrips            = 32'd0;
    compout               = 1'b0;
    compout_expect        = 1'b0;
    active_halfstrip      = 5'd0;
    halfstrip_mask_en     = 1'b0;
    thresholds_errcnt_rst = 1'b0;
    offsets_errcnt_rst    = 1'b0;
    compout_errcnt_rst    = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_pulse_en", pulse_en, 1'b0);
    check("rst_compin", compin, 1'b0);
    check("rst_ready", pulser_ready, 1'b1);
    check("rst_hs_last", halfstrips_last, 32'd0);
    check("rst_co_last", compout_last, 1'b0);
    check_counters("rst", 16'd0, 16'd0, 16'd0);
    reset = 1'b1;

    // 3 pulses, width 1, 13-clock wait: pulses at 1/15/29, samples 14/28/42.
    halfstrip_mask_en = 1'b1;
    active_halfstrip  = 5'd17;
    compout           = 1'b0;
    compout_expect    = 1'b0;
    run_train(3, 0, 12, 32'd0, 1'b1, 45, 0);
    check_counters("train_a", 16'd3, 16'd0, 16'd0);
    check("train_a_hs_last", halfstrips_last, 32'd0);

    @(negedge clock);
    thresholds_errcnt_rst = 1'b1;
    @(negedge clock);
    thresholds_errcnt_rst = 1'b0;
    check_counters("thr_clr", 16'd0, 16'd0, 16'd0);

    // Correct hit only during WAIT, strict pattern compare; fire held high afterwards.
    halfstrip_mask_en = 1'b0;
    compout           = 1'b1;
    compout_expect    = 1'b1;
    run_train(3, 0, 12, 32'h0002_0000, 1'b1, 65, 0);
    check_counters("train_b", 16'd0, 16'd0, 16'd0);
    check("train_b_hs_last", halfstrips_last, 32'h0002_0000);
    check("train_b_co_last", compout_last, 1'b1);

    // No injection, no hits, wrong compout: two failing samples each.
    compout        = 1'b0;
    compout_expect = 1'b1;
    run_train(2, 2, 3, 32'd0, 1'b0, 16, 0);
    check_counters("train_c", 16'd2, 16'd0, 16'd2);
    check("train_c_co_last", compout_last, 1'b0);

    // Zero width and zero delay; extra hit bit passes with the mask, fails without.
    halfstrip_mask_en = 1'b1;
    active_halfstrip  = 5'd1;
    compout_expect    = 1'b0;
    run_train(1, 0, 0, 32'h0000_0003, 1'b1, 4, 0);
    check_counters("train_d", 16'd2, 16'd0, 16'd2);
    check("train_d_hs_last", halfstrips_last, 32'h0000_0003);
    halfstrip_mask_en = 1'b0;
    run_train(1, 0, 0, 32'h0000_0003, 1'b1, 4, 0);
    check_counters("train_e", 16'd3, 16'd0, 16'd2);

    // Reset at edge 20 aborts the train: no pulse at 29, counters cleared.
    halfstrip_mask_en = 1'b1;
    active_halfstrip  = 5'd17;
    run_train(3, 0, 12, 32'd0, 1'b1, 35, 20);
    check_counters("abort", 16'd0, 16'd0, 16'd0);
    check("abort_hs_last", halfstrips_last, 32'd0);

    // One failing sample on both threshold and compout.
    active_halfstrip = 5'd5;
    compout          = 1'b1;
    compout_expect   = 1'b0;
    run_train(1, 0, 0, 32'd0, 1'b1, 4, 0);
    check_counters("train_g", 16'd1, 16'd0, 16'd1);
    check("train_g_co_last", compout_last, 1'b1);

    // num_pulses=0 never leaves IDLE.
    run_train(0, 0, 12, 32'd0, 1'b1, 10, 0);
    check_counters("zero_pulses", 16'd1, 16'd0, 16'd1);

    // Offset counter saturates, then a clear beats the simultaneous increment.
    @(negedge clock);
    halfstrips = 32'd1;
    repeat (70000) @(negedge clock);
    check_counters("offset_sat", 16'd1, 16'hFFFF, 16'd1);
    offsets_errcnt_rst = 1'b1;
    @(negedge clock);
    check_counters("offset_clr", 16'd1, 16'd0, 16'd1);
    offsets_errcnt_rst = 1'b0;
    halfstrips         = 32'd0;
    @(negedge clock);
    check_counters("offset_idle", 16'd1, 16'd0, 16'd1);
    check("final_hs_last", halfstrips_last, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
